// File: rtl/lz77_arb_pkg.sv
// Shared types for the LZ77 core arbiter: FSM states, FIFO entry layout
// and the FIFO address-width helper.
package lz77_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        START,
        RUN,
        DRAIN,
        RELEASE
    } state_e;

    localparam int TOKEN_W_DEFAULT = 14;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

    function automatic int fifo_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/lz77_byte_fifo.sv
// Byte FIFO with a per-entry last flag; supports push and pop in the same
// cycle (including when full) and a synchronous flush.
module lz77_byte_fifo
    import lz77_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic        pop,
    input  fifo_entry_t din,
    output fifo_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int AW = fifo_aw(DEPTH);
    localparam int CW = AW + 1;

    fifo_entry_t   mem_q [DEPTH];
    fifo_entry_t   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lz77_core_arbiter.sv
// Round-robin owner of a shared LZ77 core: buffers the owner's block in a
// byte FIFO, sequences core start/done and routes tokens back to the owner.
module lz77_core_arbiter
    import lz77_arb_pkg::*;
#(
    parameter int N_CLI      = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int TOKEN_W    = TOKEN_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CLI-1:0]     cli_req,
    input  logic [8*N_CLI-1:0]   cli_data,
    input  logic [N_CLI-1:0]     cli_valid,
    input  logic [N_CLI-1:0]     cli_last,
    output logic [N_CLI-1:0]     cli_ready,
    output logic [N_CLI-1:0]     cli_grant,
    output logic [TOKEN_W-1:0]   cli_tok,
    output logic [N_CLI-1:0]     cli_tok_valid,
    output logic [N_CLI-1:0]     cli_done,
    output logic                 core_start,
    output logic [7:0]           core_data,
    output logic                 core_last,
    input  logic                 core_load,
    input  logic [TOKEN_W-1:0]   core_token,
    input  logic                 core_token_valid,
    input  logic                 core_done,
    output logic                 underrun
);

    localparam int OW = (N_CLI > 1) ? $clog2(N_CLI) : 1;

    state_e        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_q, rr_d;
    logic          last_seen_q, last_seen_d;
    logic          underrun_q, underrun_d;

    logic          fifo_push, fifo_pop, fifo_clr;
    logic          fifo_full, fifo_empty;
    fifo_entry_t   fifo_din, fifo_head;

    logic [N_CLI-1:0] owner_oh;
    logic             filling;
    logic             head_live;
    logic             tok_live;
    logic             pick_found;
    logic [OW-1:0]    pick_idx;
    logic [OW-1:0]    cand;

    lz77_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign owner_oh      = N_CLI'(1) << owner_q;
    assign filling       = ((state_q == FILL) || (state_q == RUN)) && !fifo_full && !last_seen_q;
    assign fifo_push     = filling && cli_valid[owner_q];
    assign fifo_din.data = cli_data[8*owner_q +: 8];
    assign fifo_din.last = cli_last[owner_q];
    assign head_live     = (state_q == RUN) && !fifo_empty;
    assign tok_live      = core_token_valid && (state_q != IDLE);

    assign cli_ready     = filling ? owner_oh : '0;
    assign cli_grant     = ((state_q != IDLE) && (state_q != RELEASE)) ? owner_oh : '0;
    assign cli_done      = (state_q == RELEASE) ? owner_oh : '0;
    assign cli_tok       = tok_live ? core_token : '0;
    assign cli_tok_valid = tok_live ? owner_oh : '0;
    assign core_start    = (state_q == START);
    assign core_data     = head_live ? fifo_head.data : 8'h00;
    assign core_last     = head_live && fifo_head.last;
    assign underrun      = underrun_q;

    // Scan downward so the lowest offset from the RR pointer wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = N_CLI - 1; k >= 0; k--) begin
            cand = OW'((int'(rr_q) + k) % N_CLI);
            if (cli_req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        last_seen_d = last_seen_q;
        underrun_d  = underrun_q;
        fifo_pop    = 1'b0;
        fifo_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (fifo_full || last_seen_q) state_d = START;
            end
            START: state_d = RUN;
            RUN: begin
                if (core_load) begin
                    if (fifo_empty) begin
                        underrun_d = 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                        if (fifo_head.last) state_d = DRAIN;
                    end
                end
                if (core_done) state_d = RELEASE;
            end
            DRAIN: begin
                if (core_done) state_d = RELEASE;
            end
            RELEASE: begin
                fifo_clr    = 1'b1;
                last_seen_d = 1'b0;
                rr_d        = (owner_q == OW'(N_CLI - 1)) ? '0 : owner_q + 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (fifo_push && cli_last[owner_q]) last_seen_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_q        <= '0;
            last_seen_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            last_seen_q <= last_seen_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_lz77_core_arbiter.sv
// Directed bench for lz77_core_arbiter: bytes accepted from clients are queued
// as expected core bytes and compared when the modelled core loads them.
module tb_lz77_core_arbiter;

    localparam int N_CLI      = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int TOKEN_W    = 14;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_CLI-1:0]     cli_req;
    logic [8*N_CLI-1:0]   cli_data;
    logic [N_CLI-1:0]     cli_valid;
    logic [N_CLI-1:0]     cli_last;
    logic [N_CLI-1:0]     cli_ready;
    logic [N_CLI-1:0]     cli_grant;
    logic [TOKEN_W-1:0]   cli_tok;
    logic [N_CLI-1:0]     cli_tok_valid;
    logic [N_CLI-1:0]     cli_done;
    logic                 core_start;
    logic [7:0]           core_data;
    logic                 core_last;
    logic                 core_load;
    logic [TOKEN_W-1:0]   core_token;
    logic                 core_token_valid;
    logic                 core_done;
    logic                 underrun;

    logic [8:0] sb [$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    lz77_core_arbiter #(
        .N_CLI      (N_CLI),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TOKEN_W    (TOKEN_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cli_req          (cli_req),
        .cli_data         (cli_data),
        .cli_valid        (cli_valid),
        .cli_last         (cli_last),
        .cli_ready        (cli_ready),
        .cli_grant        (cli_grant),
        .cli_tok          (cli_tok),
        .cli_tok_valid    (cli_tok_valid),
        .cli_done         (cli_done),
        .core_start       (core_start),
        .core_data        (core_data),
        .core_last        (core_last),
        .core_load        (core_load),
        .core_token       (core_token),
        .core_token_valid (core_token_valid),
        .core_done        (core_done),
        .underrun         (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_CLI-1:0] oh(input int c);
        return N_CLI'(1) << c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input int c, input logic [7:0] b, input logic last);
        cli_valid        = '0;
        cli_last         = '0;
        cli_data         = '0;
        cli_valid[c]     = 1'b1;
        cli_last[c]      = last;
        cli_data[8*c +: 8] = b;
    endtask

    task automatic clear_client();
        cli_valid = '0;
        cli_last  = '0;
        cli_data  = '0;
    endtask

    // Drives an owner's block and a core loading one byte per cycle once running.
    task automatic run_block(input int c, input int n, input logic [7:0] base);
        int sent = 0;
        int loaded = 0;
        int cyc = 0;
        bit running = 1'b0;
        logic [8:0] exp;
        sb.delete();
        while (loaded < n && cyc < 400) begin
            clear_client();
            core_load = 1'b0;
            if (sent < n) drive_byte(c, base + 8'(sent), sent == n - 1);
            if (running) core_load = 1'b1;
            #1;
            check("ready_non_owner", 32'(cli_ready & ~oh(c)), 0);
            if (!running && sent == FIFO_DEPTH) check("ready_low_when_full", 32'(cli_ready[c]), 0);
            if (running) check("start_single_pulse", 32'(core_start), 0);
            if (core_load) begin
                check("pending_bytes", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check("core_data", 32'(core_data), 32'(exp[7:0]));
                    check("core_last", 32'(core_last), 32'(exp[8]));
                end
                loaded++;
            end
            if (cli_valid[c] && cli_ready[c]) begin
                sb.push_back({cli_last[c], cli_data[8*c +: 8]});
                sent++;
            end
            if (core_start && !running) begin
                check("bytes_at_start", sent, (n < FIFO_DEPTH) ? n : FIFO_DEPTH);
                running = 1'b1;
            end
            tick();
            cyc++;
        end
        check("block_timeout", 32'(cyc < 400), 1);
        clear_client();
        core_load = 1'b0;
        check("no_underrun", 32'(underrun), 0);
    endtask

    task automatic release_block(input int c, input logic [TOKEN_W-1:0] tok);
        core_token       = tok;
        core_token_valid = 1'b1;
        #1;
        check("tok_data", 32'(cli_tok), 32'(tok));
        check("tok_valid", 32'(cli_tok_valid), 32'(oh(c)));
        check("grant_held", 32'(cli_grant), 32'(oh(c)));
        check("done_early", 32'(cli_done), 0);
        core_token_valid = 1'b0;
        core_done        = 1'b1;
        tick();
        core_done = 1'b0;
        #1;
        check("done_pulse", 32'(cli_done), 32'(oh(c)));
        check("grant_cleared", 32'(cli_grant), 0);
        tick();
        check("done_one_cycle", 32'(cli_done), 0);
    endtask

    // Sends a full FIFO's worth of non-last bytes and steps into RUN.
    task automatic fill_and_start(input logic [7:0] base);
        int w = 0;
        sb.delete();
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            drive_byte(0, base + 8'(i), 1'b0);
            #1;
            check("fill_ready", 32'(cli_ready[0]), 1);
            sb.push_back({1'b0, base + 8'(i)});
            tick();
        end
        clear_client();
        #1;
        while (!core_start && w < 10) begin
            tick();
            w++;
        end
        check("start_seen", 32'(core_start), 1);
        tick();
    endtask

    task automatic load_one(input string tag);
        logic [8:0] exp;
        core_load = 1'b1;
        #1;
        exp = sb.pop_front();
        check(tag, 32'(core_data), 32'(exp[7:0]));
        check({tag, "_last"}, 32'(core_last), 32'(exp[8]));
        tick();
        core_load = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        cli_req          = '0;
        clear_client();
        core_load        = 1'b0;
        core_done        = 1'b0;
        core_token_valid = 1'b0;
        core_token       = '0;
        tick();
        tick();
        check("rst_grant", 32'(cli_grant), 0);
        check("rst_ready", 32'(cli_ready), 0);
        check("rst_start", 32'(core_start), 0);
        check("rst_done", 32'(cli_done), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_core_data", 32'(core_data), 0);
        rst = 1'b0;

        // Both clients requesting: 0 first, then 1, then 0 again after wrap.
        cli_req = 2'b11;
        tick();
        check("rr_first_grant", 32'(cli_grant), 32'b01);
        run_block(0, 3, 8'h41);
        release_block(0, 14'h0123);
        tick();
        check("rr_second_grant", 32'(cli_grant), 32'b10);
        run_block(1, 3, 8'h51);
        release_block(1, 14'h1ABC);
        tick();
        check("rr_wrap_grant", 32'(cli_grant), 32'b01);

        // Long block through an 8-deep FIFO; request dropped mid-block.
        cli_req = 2'b00;
        run_block(0, 20, 8'h60);
        release_block(0, 14'h2DEF);

        core_token       = 14'h3FFF;
        core_token_valid = 1'b1;
        #1;
        check("idle_tok_valid", 32'(cli_tok_valid), 0);
        check("idle_tok", 32'(cli_tok), 0);
        core_token_valid = 1'b0;
        tick();
        check("idle_no_grant", 32'(cli_grant), 0);

        // Underrun: core loads past the buffered bytes before the last arrives.
        cli_req = 2'b01;
        tick();
        check("ur_grant", 32'(cli_grant), 32'b01);
        cli_req = 2'b00;
        fill_and_start(8'h70);
        for (int i = 0; i < FIFO_DEPTH; i++) load_one("ur_core_data");
        core_load = 1'b1;
        #1;
        check("ur_empty_data", 32'(core_data), 0);
        check("ur_not_yet", 32'(underrun), 0);
        tick();
        core_load = 1'b0;
        #1;
        check("ur_set", 32'(underrun), 1);
        drive_byte(0, 8'h7F, 1'b1);
        #1;
        check("ur_last_ready", 32'(cli_ready[0]), 1);
        sb.push_back({1'b1, 8'h7F});
        tick();
        clear_client();
        load_one("ur_last_byte");
        release_block(0, 14'h0AAA);
        check("ur_sticky", 32'(underrun), 1);

        // Reset in RUN with bytes still buffered.
        cli_req = 2'b01;
        tick();
        check("rs_grant", 32'(cli_grant), 32'b01);
        cli_req = 2'b00;
        fill_and_start(8'h90);
        for (int i = 0; i < 4; i++) load_one("rs_core_data");
        rst = 1'b1;
        #1;
        check("rs_no_done_before", 32'(cli_done), 0);
        tick();
        check("rs_grant_clear", 32'(cli_grant), 0);
        check("rs_no_done", 32'(cli_done), 0);
        check("rs_ready_clear", 32'(cli_ready), 0);
        check("rs_underrun_clear", 32'(underrun), 0);
        check("rs_core_data", 32'(core_data), 0);
        rst     = 1'b0;
        cli_req = 2'b11;
        tick();
        check("rs_pointer_cleared", 32'(cli_grant), 32'b01);
        cli_req = 2'b00;
        run_block(0, 3, 8'hA0);
        release_block(0, 14'h0555);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
